// File: rtl/csr_pkg.sv
// Shared constants for the LoongArch-style CSR file: CSR numbers, exception codes,
// register field positions and the masked-write merge helper.
package csr_pkg;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;

  localparam int unsigned IS_TI  = 11;
  localparam int unsigned IS_IPI = 12;

  localparam int unsigned TCFG_EN       = 0;
  localparam int unsigned TCFG_PERIODIC = 1;

  function automatic logic [31:0] mask_merge(input logic [31:0] old_val,
                                             input logic [31:0] mask,
                                             input logic [31:0] value);
    return (mask & value) | (~mask & old_val);
  endfunction

endpackage

// File: rtl/csr_timer.sv
// TCFG register and timer down-counter; flags the cycle in which an enabled timer sits at zero.
module csr_timer
  import csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        tcfg_we_i,
  input  logic [31:0] wmask_i,
  input  logic [31:0] wvalue_i,
  output logic [31:0] tcfg_o,
  output logic [31:0] tcnt_o,
  output logic        ti_pulse_o
);

  logic [31:0] tcfg_q, tcfg_d;
  logic [31:0] tcnt_q, tcnt_d;
  logic        en;
  logic        periodic;

  assign en       = tcfg_q[TCFG_EN];
  assign periodic = tcfg_q[TCFG_PERIODIC];

  always_comb begin
    tcfg_d = tcfg_we_i ? mask_merge(tcfg_q, wmask_i, wvalue_i) : tcfg_q;
    tcnt_d = tcnt_q;
    if (tcfg_we_i && tcfg_d[TCFG_EN]) begin
      tcnt_d = {tcfg_d[31:2], 2'b00};
    end else if (en && (tcnt_q != '1)) begin
      // All-ones is the parked state of an expired one-shot timer.
      if (tcnt_q == '0) begin
        tcnt_d = periodic ? {tcfg_q[31:2], 2'b00} : '1;
      end else begin
        tcnt_d = tcnt_q - 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tcfg_q <= '0;
      tcnt_q <= '1;
    end else begin
      tcfg_q <= tcfg_d;
      tcnt_q <= tcnt_d;
    end
  end

  assign tcfg_o     = tcfg_q;
  assign tcnt_o     = tcnt_q;
  assign ti_pulse_o = en && (tcnt_q == '0);

endmodule

// File: rtl/csr_file_param.sv
// LoongArch-style CSR file: csrrd/csrwr/csrxchg access, exception entry/return state,
// interrupt status/pending, timer and free-running stable counter.
module csr_file_param
  import csr_pkg::*;
#(
  parameter int unsigned SAVE_NUM = 4,
  parameter int unsigned HWI_NUM  = 8,
  parameter logic [31:0] COREID   = 32'h0,
  parameter int unsigned CNT_W    = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               csr_re,
  input  logic [13:0]        csr_rnum,
  output logic [31:0]        csr_rvalue,
  input  logic               csr_we,
  input  logic [13:0]        csr_wnum,
  input  logic [31:0]        csr_wmask,
  input  logic [31:0]        csr_wvalue,
  input  logic [HWI_NUM-1:0] hwi_in,
  input  logic               ipi_in,
  input  logic               wb_ex,
  input  logic [5:0]         wb_ecode,
  input  logic [8:0]         wb_esubcode,
  input  logic [31:0]        wb_pc,
  input  logic [31:0]        wb_vaddr,
  input  logic               eret_flush,
  output logic               has_int,
  output logic [31:0]        ex_entry,
  output logic [31:0]        ertn_entry,
  output logic [31:0]        tid_rvalue,
  output logic [CNT_W-1:0]   cnt_value
);

  logic [1:0]       crmd_plv_q, crmd_plv_d;
  logic             crmd_ie_q, crmd_ie_d;
  logic             crmd_da_q, crmd_da_d;
  logic [1:0]       prmd_pplv_q, prmd_pplv_d;
  logic             prmd_pie_q, prmd_pie_d;
  logic [12:0]      lie_q, lie_d;
  logic [1:0]       is_sw_q, is_sw_d;
  logic [7:0]       is_hw_q, is_hw_d;
  logic             is_ti_q, is_ti_d;
  logic             is_ipi_q, is_ipi_d;
  logic [5:0]       ecode_q, ecode_d;
  logic [8:0]       esub_q, esub_d;
  logic [31:0]      era_q, era_d;
  logic [31:0]      badv_q, badv_d;
  logic [31:0]      tid_q, tid_d;
  logic [25:0]      eentry_va_q, eentry_va_d;
  logic [31:0]      save_q [SAVE_NUM];
  logic [31:0]      save_d [SAVE_NUM];
  logic [CNT_W-1:0] cnt_q;

  logic [31:0] tcfg, tcnt;
  logic        ti_pulse;
  logic [12:0] is_all;
  logic [31:0] wr_word;
  logic        ticlr_clr;

  csr_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .tcfg_we_i  (csr_we && (csr_wnum == CSR_TCFG)),
    .wmask_i    (csr_wmask),
    .wvalue_i   (csr_wvalue),
    .tcfg_o     (tcfg),
    .tcnt_o     (tcnt),
    .ti_pulse_o (ti_pulse)
  );

  assign is_all = {is_ipi_q, is_ti_q, 1'b0, is_hw_q, is_sw_q};

  // Architectural view of a CSR word; shared by the read port and the masked-write merge.
  function automatic logic [31:0] csr_view(input logic [13:0] num);
    logic [31:0] v;
    v = '0;
    case (num)
      CSR_CRMD:   v = {28'b0, crmd_da_q, crmd_ie_q, crmd_plv_q};
      CSR_PRMD:   v = {29'b0, prmd_pie_q, prmd_pplv_q};
      CSR_ECFG:   v = {19'b0, lie_q};
      CSR_ESTAT:  v = {1'b0, esub_q, ecode_q, 3'b0, is_all};
      CSR_ERA:    v = era_q;
      CSR_BADV:   v = badv_q;
      CSR_EENTRY: v = {eentry_va_q, 6'b0};
      CSR_TID:    v = tid_q;
      CSR_TCFG:   v = tcfg;
      CSR_TVAL:   v = tcnt;
      default: begin
        for (int unsigned i = 0; i < SAVE_NUM; i++) begin
          if (num == CSR_SAVE0 + 14'(i)) v = save_q[i];
        end
      end
    endcase
    return v;
  endfunction

  assign csr_rvalue = csr_re ? csr_view(csr_rnum) : '0;
  assign wr_word    = mask_merge(csr_view(csr_wnum), csr_wmask, csr_wvalue);
  assign ticlr_clr  = csr_we && (csr_wnum == CSR_TICLR) && csr_wmask[0] && csr_wvalue[0];

  always_comb begin
    crmd_plv_d  = crmd_plv_q;
    crmd_ie_d   = crmd_ie_q;
    crmd_da_d   = crmd_da_q;
    prmd_pplv_d = prmd_pplv_q;
    prmd_pie_d  = prmd_pie_q;
    lie_d       = lie_q;
    is_sw_d     = is_sw_q;
    ecode_d     = ecode_q;
    esub_d      = esub_q;
    era_d       = era_q;
    badv_d      = badv_q;
    tid_d       = tid_q;
    eentry_va_d = eentry_va_q;
    save_d      = save_q;

    // Exception commit owns every register it touches for this cycle.
    if (wb_ex) begin
      prmd_pie_d  = crmd_ie_q;
      prmd_pplv_d = crmd_plv_q;
      crmd_ie_d   = 1'b0;
      crmd_plv_d  = 2'b0;
      era_d       = wb_pc;
      ecode_d     = wb_ecode;
      esub_d      = wb_esubcode;
      if ((wb_ecode == ECODE_ADE) && (wb_esubcode == '0)) begin
        badv_d = wb_pc;
      end else if ((wb_ecode == ECODE_ADE) || (wb_ecode == ECODE_ALE)) begin
        badv_d = wb_vaddr;
      end
    end else begin
      if (eret_flush) begin
        crmd_ie_d  = prmd_pie_q;
        crmd_plv_d = prmd_pplv_q;
      end else if (csr_we && (csr_wnum == CSR_CRMD)) begin
        crmd_plv_d = wr_word[1:0];
        crmd_ie_d  = wr_word[2];
        crmd_da_d  = wr_word[3];
      end
      if (csr_we && (csr_wnum == CSR_PRMD)) begin
        prmd_pplv_d = wr_word[1:0];
        prmd_pie_d  = wr_word[2];
      end
      if (csr_we && (csr_wnum == CSR_ESTAT)) is_sw_d = wr_word[1:0];
      if (csr_we && (csr_wnum == CSR_ERA))   era_d   = wr_word;
      if (csr_we && (csr_wnum == CSR_BADV))  badv_d  = wr_word;
    end

    if (csr_we && (csr_wnum == CSR_ECFG))   lie_d       = wr_word[12:0];
    if (csr_we && (csr_wnum == CSR_EENTRY)) eentry_va_d = wr_word[31:6];
    if (csr_we && (csr_wnum == CSR_TID))    tid_d       = wr_word;
    for (int unsigned i = 0; i < SAVE_NUM; i++) begin
      if (csr_we && (csr_wnum == CSR_SAVE0 + 14'(i))) save_d[i] = wr_word;
    end

    is_hw_d                = '0;
    is_hw_d[HWI_NUM-1:0]   = hwi_in;
    is_ipi_d               = ipi_in;
    // A fresh timer expiry beats a simultaneous TICLR so no tick is lost.
    if (ti_pulse) begin
      is_ti_d = 1'b1;
    end else if (ticlr_clr) begin
      is_ti_d = 1'b0;
    end else begin
      is_ti_d = is_ti_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crmd_plv_q  <= '0;
      crmd_ie_q   <= 1'b0;
      crmd_da_q   <= 1'b1;
      prmd_pplv_q <= '0;
      prmd_pie_q  <= 1'b0;
      lie_q       <= '0;
      is_sw_q     <= '0;
      is_hw_q     <= '0;
      is_ti_q     <= 1'b0;
      is_ipi_q    <= 1'b0;
      ecode_q     <= '0;
      esub_q      <= '0;
      era_q       <= '0;
      badv_q      <= '0;
      tid_q       <= COREID;
      eentry_va_q <= '0;
      for (int unsigned i = 0; i < SAVE_NUM; i++) save_q[i] <= '0;
      cnt_q       <= '0;
    end else begin
      crmd_plv_q  <= crmd_plv_d;
      crmd_ie_q   <= crmd_ie_d;
      crmd_da_q   <= crmd_da_d;
      prmd_pplv_q <= prmd_pplv_d;
      prmd_pie_q  <= prmd_pie_d;
      lie_q       <= lie_d;
      is_sw_q     <= is_sw_d;
      is_hw_q     <= is_hw_d;
      is_ti_q     <= is_ti_d;
      is_ipi_q    <= is_ipi_d;
      ecode_q     <= ecode_d;
      esub_q      <= esub_d;
      era_q       <= era_d;
      badv_q      <= badv_d;
      tid_q       <= tid_d;
      eentry_va_q <= eentry_va_d;
      save_q      <= save_d;
      cnt_q       <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign has_int    = (|(is_all & lie_q)) && crmd_ie_q;
  assign ex_entry   = {eentry_va_q, 6'b0};
  assign ertn_entry = era_q;
  assign tid_rvalue = tid_q;
  assign cnt_value  = cnt_q;

endmodule

// File: tb/tb_csr_file_param.sv
// Self-checking bench for csr_file_param: register table, exception/timer/interrupt
// sequences, and a randomized run against a word-level CSR model.
module tb_csr_file_param;

  localparam int unsigned SAVE_NUM = 4;
  localparam int unsigned HWI_NUM  = 8;
  localparam logic [31:0] COREID   = 32'h0000_0007;
  localparam int unsigned CNT_W    = 64;

  logic               clk = 1'b0;
  logic               rst;
  logic               csr_re;
  logic [13:0]        csr_rnum;
  logic [31:0]        csr_rvalue;
  logic               csr_we;
  logic [13:0]        csr_wnum;
  logic [31:0]        csr_wmask;
  logic [31:0]        csr_wvalue;
  logic [HWI_NUM-1:0] hwi_in;
  logic               ipi_in;
  logic               wb_ex;
  logic [5:0]         wb_ecode;
  logic [8:0]         wb_esubcode;
  logic [31:0]        wb_pc;
  logic [31:0]        wb_vaddr;
  logic               eret_flush;
  logic               has_int;
  logic [31:0]        ex_entry;
  logic [31:0]        ertn_entry;
  logic [31:0]        tid_rvalue;
  logic [CNT_W-1:0]   cnt_value;

  csr_file_param #(
    .SAVE_NUM (SAVE_NUM),
    .HWI_NUM  (HWI_NUM),
    .COREID   (COREID),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .csr_re      (csr_re),
    .csr_rnum    (csr_rnum),
    .csr_rvalue  (csr_rvalue),
    .csr_we      (csr_we),
    .csr_wnum    (csr_wnum),
    .csr_wmask   (csr_wmask),
    .csr_wvalue  (csr_wvalue),
    .hwi_in      (hwi_in),
    .ipi_in      (ipi_in),
    .wb_ex       (wb_ex),
    .wb_ecode    (wb_ecode),
    .wb_esubcode (wb_esubcode),
    .wb_pc       (wb_pc),
    .wb_vaddr    (wb_vaddr),
    .eret_flush  (eret_flush),
    .has_int     (has_int),
    .ex_entry    (ex_entry),
    .ertn_entry  (ertn_entry),
    .tid_rvalue  (tid_rvalue),
    .cnt_value   (cnt_value)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [13:0] n, output logic [31:0] v);
    csr_re   = 1'b1;
    csr_rnum = n;
    #1;
    v = csr_rvalue;
  endtask

  task automatic chk_rd(input string name, input logic [13:0] n, input logic [31:0] exp);
    logic [31:0] v;
    rd(n, v);
    check(name, {32'b0, v}, {32'b0, exp});
  endtask

  task automatic wr(input logic [13:0] n, input logic [31:0] m, input logic [31:0] v);
    csr_we     = 1'b1;
    csr_wnum   = n;
    csr_wmask  = m;
    csr_wvalue = v;
    tick();
    csr_we     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic is11(output logic b);
    logic [31:0] v;
    rd(14'h005, v);
    b = v[11];
  endtask

  // Advance until TVAL reads zero; n = number of edges waited.
  task automatic wait_tval_zero(input string name, output int n);
    logic [31:0] v;
    n = 0;
    rd(14'h042, v);
    while ((v != 32'h0) && (n < 40)) begin
      tick();
      n++;
      rd(14'h042, v);
    end
    check(name, {32'b0, v}, 64'h0);
  endtask

  typedef struct {
    string       name;
    logic [13:0] wnum;
    logic [31:0] wmask;
    logic [31:0] wvalue;
    logic [13:0] rnum;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  // Word-level model: each CSR is a 32-bit word with a fixed writable mask.
  logic [31:0] m_csr [int];
  logic [7:0]  m_hw;
  logic        m_ipi;
  logic [63:0] m_cnt;

  function automatic logic [31:0] m_wmask(input int n);
    if (n == 'h0) return 32'h0000_000F;
    if (n == 'h1) return 32'h0000_0007;
    if (n == 'h4) return 32'h0000_1FFF;
    if (n == 'h5) return 32'h0000_0003;
    if (n == 'h6 || n == 'h7 || n == 'h40) return 32'hFFFF_FFFF;
    if (n == 'hC) return 32'hFFFF_FFC0;
    if (n >= 'h30 && n < 'h30 + int'(SAVE_NUM)) return 32'hFFFF_FFFF;
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_read(input int n);
    if (n == 'h5) return m_csr[n] | {19'b0, m_ipi, 2'b0, m_hw, 2'b0};
    if (n == 'h42) return 32'hFFFF_FFFF;
    if (m_wmask(n) != 0) return m_csr[n];
    return 32'h0;
  endfunction

  task automatic m_reset();
    m_csr.delete();
    m_csr['h0] = 32'h8;
    foreach (m_csr[k]) m_csr[k] = m_csr[k];
    m_csr['h1] = 0; m_csr['h4] = 0; m_csr['h5] = 0; m_csr['h6] = 0; m_csr['h7] = 0;
    m_csr['hC] = 0; m_csr['h40] = COREID;
    for (int i = 0; i < int'(SAVE_NUM); i++) m_csr['h30 + i] = 0;
    m_hw = 0; m_ipi = 0; m_cnt = 0;
  endtask

  initial begin
    logic [31:0] v;
    logic        b;
    int          n;
    int          pre_ticks;
    int          nums[16] = '{'h0, 'h1, 'h4, 'h5, 'h6, 'h7, 'hC, 'h30, 'h31, 'h33, 'h34,
                              'h3F, 'h40, 'h42, 'h99, 'h2};

    vecs[0]  = '{"save0_mask",  14'h030, 32'hFFFF_0000, 32'h1234_5678, 14'h030, 32'h1234_0000};
    vecs[1]  = '{"save_oob",    14'h034, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 14'h034, 32'h0};
    vecs[2]  = '{"era",         14'h006, 32'hFFFF_FFFF, 32'h1C00_0123, 14'h006, 32'h1C00_0123};
    vecs[3]  = '{"eentry",      14'h00C, 32'hFFFF_FFFF, 32'h1C00_8FFF, 14'h00C, 32'h1C00_8FC0};
    vecs[4]  = '{"estat_sw",    14'h005, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 14'h005, 32'h0000_0003};
    vecs[5]  = '{"prmd",        14'h001, 32'hFFFF_FFFF, 32'h0000_00FF, 14'h001, 32'h0000_0007};
    vecs[6]  = '{"tid",         14'h040, 32'hFFFF_FFFF, 32'hABCD_0001, 14'h040, 32'hABCD_0001};
    vecs[7]  = '{"unmapped",    14'h099, 32'hFFFF_FFFF, 32'h0000_0001, 14'h099, 32'h0};
    vecs[8]  = '{"tval_ro",     14'h042, 32'hFFFF_FFFF, 32'h0000_0123, 14'h042, 32'hFFFF_FFFF};
    vecs[9]  = '{"ticlr_rd0",   14'h044, 32'hFFFF_FFFF, 32'h0000_0001, 14'h044, 32'h0};
    vecs[10] = '{"crmd_part",   14'h000, 32'h0000_0007, 32'h0000_0003, 14'h000, 32'h0000_000B};
    vecs[11] = '{"ecfg",        14'h004, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 14'h004, 32'h0000_1FFF};
    vecs[12] = '{"save3_mask",  14'h033, 32'h0000_FFFF, 32'h55AA_55AA, 14'h033, 32'h0000_55AA};
    vecs[13] = '{"save1_nomask",14'h031, 32'h0000_0000, 32'hFFFF_FFFF, 14'h031, 32'h0};
    vecs[14] = '{"badv",        14'h007, 32'hFFFF_FFFF, 32'h0000_0FF0, 14'h007, 32'h0000_0FF0};

    csr_re = 0; csr_rnum = 0; csr_we = 0; csr_wnum = 0; csr_wmask = 0; csr_wvalue = 0;
    hwi_in = 0; ipi_in = 0; wb_ex = 0; wb_ecode = 0; wb_esubcode = 0; wb_pc = 0;
    wb_vaddr = 0; eret_flush = 0;
    do_reset();

    // Reset state.
    check("rst_cnt", cnt_value, 64'h0);
    chk_rd("rst_crmd", 14'h000, 32'h8);
    chk_rd("rst_tval", 14'h042, 32'hFFFF_FFFF);
    chk_rd("rst_tcfg", 14'h041, 32'h0);
    check("rst_has_int", {63'b0, has_int}, 64'h0);
    check("rst_ex_entry", {32'b0, ex_entry}, 64'h0);
    check("rst_ertn_entry", {32'b0, ertn_entry}, 64'h0);
    check("rst_tid", {32'b0, tid_rvalue}, {32'b0, COREID});

    foreach (vecs[i]) begin
      wr(vecs[i].wnum, vecs[i].wmask, vecs[i].wvalue);
      chk_rd(vecs[i].name, vecs[i].rnum, vecs[i].exp);
    end
    csr_re = 0; csr_rnum = 14'h006; #1;
    check("re_low_zero", {32'b0, csr_rvalue}, 64'h0);
    check("ertn_entry", {32'b0, ertn_entry}, 64'h1C00_0123);
    check("ex_entry", {32'b0, ex_entry}, 64'h1C00_8FC0);
    check("tid_out", {32'b0, tid_rvalue}, 64'hABCD_0001);

    // Exception entry and return.
    wr(14'h000, 32'h7, 32'h7);
    check("sw_int_pending", {63'b0, has_int}, 64'h1);
    wb_ex = 1; wb_ecode = 6'h08; wb_esubcode = 9'h0; wb_pc = 32'h1C00_0100; wb_vaddr = 32'hDEAD;
    tick();
    wb_ex = 0;
    chk_rd("ex_prmd", 14'h001, 32'h7);
    chk_rd("ex_crmd", 14'h000, 32'h8);
    chk_rd("ex_era", 14'h006, 32'h1C00_0100);
    chk_rd("ex_badv_ade_pc", 14'h007, 32'h1C00_0100);
    chk_rd("ex_estat", 14'h005, 32'h0008_0003);
    check("ex_int_masked", {63'b0, has_int}, 64'h0);
    eret_flush = 1; tick(); eret_flush = 0;
    chk_rd("eret_crmd", 14'h000, 32'hF);

    wb_ex = 1; wb_ecode = 6'h09; wb_esubcode = 9'h3; wb_pc = 32'h200; wb_vaddr = 32'h1234;
    tick();
    wb_ex = 0;
    chk_rd("ale_badv", 14'h007, 32'h1234);
    chk_rd("ale_estat", 14'h005, 32'h00C9_0003);
    wb_ex = 1; wb_ecode = 6'h0B; wb_esubcode = 9'h0; wb_pc = 32'h300; wb_vaddr = 32'h5678;
    tick();
    wb_ex = 0;
    chk_rd("other_badv_hold", 14'h007, 32'h1234);
    chk_rd("other_era", 14'h006, 32'h300);

    // Exception and CRMD write in the same cycle.
    wr(14'h000, 32'h7, 32'h7);
    wb_ex = 1; wb_ecode = 6'h0; wb_esubcode = 9'h0;
    wr(14'h000, 32'h7, 32'h5);
    wb_ex = 0;
    chk_rd("ex_vs_wr_crmd", 14'h000, 32'h8);
    chk_rd("ex_vs_wr_prmd", 14'h001, 32'h7);
    wr(14'h005, 32'hFFFF_FFFF, 32'h0);
    wr(14'h004, 32'hFFFF_FFFF, 32'h0);

    // One-shot timer.
    wr(14'h041, 32'hFFFF_FFFF, 32'h9);
    for (int k = 8; k >= 0; k--) begin
      chk_rd("oneshot_tval", 14'h042, 32'(k));
      is11(b);
      check("oneshot_ti_low", {63'b0, b}, 64'h0);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      chk_rd("oneshot_hold", 14'h042, 32'hFFFF_FFFF);
      is11(b);
      check("oneshot_ti_high", {63'b0, b}, 64'h1);
      tick();
    end
    wr(14'h044, 32'h1, 32'h1);
    is11(b);
    check("ticlr_clear", {63'b0, b}, 64'h0);
    repeat (12) tick();
    is11(b);
    check("ticlr_stays", {63'b0, b}, 64'h0);

    // Periodic timer.
    wr(14'h041, 32'hFFFF_FFFF, 32'hB);
    wait_tval_zero("periodic_first_zero", n);
    tick();
    wait_tval_zero("periodic_second_zero", n);
    check("periodic_period", 64'(n + 1), 64'd9);
    tick();
    is11(b);
    check("periodic_ti_set", {63'b0, b}, 64'h1);
    wr(14'h044, 32'h1, 32'h1);
    is11(b);
    check("periodic_ticlr", {63'b0, b}, 64'h0);
    wait_tval_zero("periodic_third_zero", n);
    wr(14'h044, 32'h1, 32'h1);
    is11(b);
    check("set_beats_clear", {63'b0, b}, 64'h1);

    // Interrupt pending paths.
    wr(14'h041, 32'hFFFF_FFFF, 32'h0);
    wr(14'h044, 32'h1, 32'h1);
    wr(14'h004, 32'hFFFF_FFFF, 32'h4);
    wr(14'h000, 32'h4, 32'h4);
    check("int_idle", {63'b0, has_int}, 64'h0);
    hwi_in = 8'h01; tick();
    check("hwi0_int", {63'b0, has_int}, 64'h1);
    hwi_in = 8'h00; tick();
    check("hwi0_drop", {63'b0, has_int}, 64'h0);
    wr(14'h004, 32'hFFFF_FFFF, 32'h1000);
    ipi_in = 1; tick();
    check("ipi_int", {63'b0, has_int}, 64'h1);
    chk_rd("ipi_estat", 14'h005, 32'h0000_1000);
    ipi_in = 0; tick();
    check("ipi_drop", {63'b0, has_int}, 64'h0);
    wr(14'h004, 32'hFFFF_FFFF, 32'h200);
    hwi_in = 8'h80; tick();
    check("hwi7_int", {63'b0, has_int}, 64'h1);
    wr(14'h000, 32'h4, 32'h0);
    check("ie_gate", {63'b0, has_int}, 64'h0);
    hwi_in = 0;

    // Reset in the middle of a countdown.
    wr(14'h041, 32'hFFFF_FFFF, 32'h41);
    repeat (3) tick();
    do_reset();
    chk_rd("midrst_tval", 14'h042, 32'hFFFF_FFFF);
    check("midrst_cnt", cnt_value, 64'h0);
    chk_rd("midrst_crmd", 14'h000, 32'h8);
    repeat (5) tick();
    check("cnt_five", cnt_value, 64'd5);

    // Randomized traffic against the model; timer stays disabled.
    do_reset();
    m_reset();
    pre_ticks = 0;
    for (int c = 0; c < 400; c++) begin
      int r;
      logic [13:0] rn;
      r = $urandom_range(0, 9);
      hwi_in = 8'($urandom);
      ipi_in = 1'($urandom);
      if (r < 5) begin
        csr_we = 1; csr_wnum = 14'(nums[$urandom_range(0, 15)]);
        csr_wmask = $urandom; csr_wvalue = $urandom;
      end else if (r == 5) begin
        wb_ex = 1;
        case ($urandom_range(0, 3))
          0: wb_ecode = 6'h08;
          1: wb_ecode = 6'h09;
          2: wb_ecode = 6'h0B;
          default: wb_ecode = 6'($urandom);
        endcase
        wb_esubcode = ($urandom_range(0, 1) == 0) ? 9'h0 : 9'($urandom);
        wb_pc = $urandom; wb_vaddr = $urandom;
      end else if (r == 6) begin
        eret_flush = 1;
      end
      case ($urandom_range(0, 2))
        0: rn = 14'h041;
        1: rn = 14'h044;
        default: rn = 14'(nums[$urandom_range(0, 15)]);
      endcase
      rd(rn, v);
      check("rand_read", {32'b0, v}, {32'b0, m_read(int'(rn))});
      check("rand_has_int", {63'b0, has_int},
            {63'b0, (|(m_read('h5) & m_csr['h4] & 32'h1FFF)) && m_csr['h0][2]});
      check("rand_cnt", cnt_value, m_cnt);
      check("rand_ertn", {32'b0, ertn_entry}, {32'b0, m_csr['h6]});
      tick();
      if (wb_ex) begin
        m_csr['h1] = m_csr['h0] & 32'h7;
        m_csr['h0] = m_csr['h0] & ~32'h7;
        m_csr['h6] = wb_pc;
        m_csr['h5] = {1'b0, wb_esubcode, wb_ecode, 14'b0, m_csr['h5][1:0]};
        if (wb_ecode == 6'h08 && wb_esubcode == 9'h0) m_csr['h7] = wb_pc;
        else if (wb_ecode == 6'h08 || wb_ecode == 6'h09) m_csr['h7] = wb_vaddr;
      end else if (eret_flush) begin
        m_csr['h0] = (m_csr['h0] & ~32'h7) | (m_csr['h1] & 32'h7);
      end else if (csr_we && m_wmask(int'(csr_wnum)) != 0) begin
        m_csr[int'(csr_wnum)] = (m_csr[int'(csr_wnum)] & ~(csr_wmask & m_wmask(int'(csr_wnum))))
                              | (csr_wvalue & csr_wmask & m_wmask(int'(csr_wnum)));
      end
      m_hw  = hwi_in;
      m_ipi = ipi_in;
      m_cnt = m_cnt + 1;
      pre_ticks++;
      csr_we = 0; wb_ex = 0; eret_flush = 0;
    end
    check("rand_final_cnt", cnt_value, 64'(pre_ticks));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
